adder_rr_sched: RTL
===================

Name: adder_rr_sched

Overview:
- Round-robin scheduler sharing one `adder` instance between NUM_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake. The block grants one requester, registers its operands, drives the shared adder, and holds the registered WIDTH+1-bit result with the winner's ID until the consumer accepts it.
- Sits between several arithmetic clients and a single adder in area-constrained datapaths.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 8, operand width in bits (>=1).
- ALGORITHM, 0, passed to the adder: 0 ripple-carry, 1 carry-look-ahead.
- ID_W, $clog2(NUM_REQ), width of the requester index (derived localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_in0  in  NUM_REQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH].
- req_in1  in  NUM_REQ*WIDTH  packed operand B; same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- rsp_sum  out  WIDTH+1  in0+in1 including carry-out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0) sets: state=IDLE, rr_ptr=0, operand/ID/sum registers=0, rsp_valid=0, busy=0. req_ready is 0 while in reset.
- The FSM has states IDLE, EXEC, RESP.
- IDLE:
  - grant = first set bit of req_valid, searching from rr_ptr upward with wrap at NUM_REQ.
  - req_ready = one-hot grant, driven combinationally from req_valid and rr_ptr. It is 0 if no request is pending.
  - On handshake (any req_valid&req_ready): capture the granted in0/in1 and ID, set rr_ptr = (grant+1) mod NUM_REQ, go to EXEC.
  - No request: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - Registered operands drive the adder, which is purely combinational.
  - The sum is registered into rsp_sum. Go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id are held stable.
  - On rsp_ready=1, go to IDLE and drop rsp_valid next cycle. Otherwise hold (backpressure unbounded).
  - req_ready=0.
- Latency: handshake at edge T gives rsp_valid=1 from edge T+2. The earliest next accept is the edge after the rsp handshake. Peak throughput is one op per 3 cycles.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 grants.
- Non-power-of-2 NUM_REQ: pointer wrap is at NUM_REQ, not 2^ID_W.
- Arithmetic: rsp_sum is the full unsigned sum, WIDTH+1 bits, with carry in the MSB. There is no truncation and no signed interpretation. All-ones+all-ones = {1,1..10}.
- req_valid dropping without a handshake is legal and has no effect. Operands are sampled only at the handshake edge, so later changes do not alter the result.
- Reset asserted mid-operation (EXEC or RESP): the in-flight result is discarded, rsp_valid drops immediately (asynchronously), rr_ptr=0.
- A simultaneous request and response is impossible by construction, because req_ready=0 outside IDLE.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum typedef (IDLE/EXEC/RESP);
  - localparams ALG_RIPPLE=0 and ALG_CLA=1;
  - a function rr_pick(valid, ptr) returning the granted index.
- One sub-module: the existing `adder`, instantiated once with WIDTH and ALGORITHM. Its WIDTH+1-bit `sum` feeds the rsp_sum register.
- The arbitration logic stays inline; no separate arbiter module.

Test Plan (NUM_REQ=4, WIDTH=8, run for ALGORITHM=0 and 1):
- Single op: req 2 valid with in0=0x7F, in1=0x01, rsp_ready=1 -> req_ready=4'b0100; rsp_valid two cycles after the handshake with rsp_sum=9'h080, rsp_id=2; rr_ptr=3.
- Carry-out: req 0 with in0=0xFF, in1=0xFF -> rsp_sum=9'h1FE. Also 0x00+0x00 -> 9'h000.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches, with 3 cycles per op.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_sum/rsp_id stable, req_ready=0 throughout; a new grant occurs only after rsp_ready=1.
- Pointer skip: rr_ptr=1, only req 3 and req 0 valid -> grant 3 first, then 0.
- Mid-op reset: assert rst_n=0 during RESP -> rsp_valid=0 and busy=0 without waiting for a clock edge. After release, req 1 alone is granted with correct sum and rsp_id=1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the adder round-robin scheduler.
//   state_t    : scheduler FSM encoding (IDLE / EXEC / RESP)
//   ALG_*      : adder architecture selectors
//   MAX_REQ    : widest request vector rr_pick can search
//   rr_pick()  : first set bit of valid at or above ptr, wrapping at num_req
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ALG_RIPPLE = 0;
  localparam int ALG_CLA    = 1;

  localparam int MAX_REQ = 32;

  // Callers pad valid to MAX_REQ bits. The wrap is at num_req rather than a
  // power of two, so non-power-of-2 requester counts never select a
  // nonexistent index. Returns ptr when nothing is valid; the caller qualifies
  // the result with |valid.
  function automatic logic [31:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input logic [31:0] ptr,
                                          input logic [31:0] num_req);
    logic [31:0] idx;
    logic [31:0] pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (32'(k) < num_req) begin
        idx = ptr + 32'(k);
        if (idx >= num_req) idx = idx - num_req;
        if (!found && valid[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder.sv
// Combinational unsigned adder with selectable architecture.
//   a, b : WIDTH-bit operands
//   sum  : WIDTH+1-bit result; the MSB is the carry-out
// ALGORITHM selects ripple-carry (ALG_RIPPLE) or carry-look-ahead (ALG_CLA).
module adder
  import arith_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ALGORITHM = ALG_RIPPLE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  generate
    if (ALGORITHM == ALG_CLA) begin : g_cla
      // Each carry is built directly from the generate/propagate terms, so
      // no carry depends on the carry below it.
      always_comb begin
        logic term;
        carry = '0;
        term  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) term = term & prop[k];
            carry[i+1] = carry[i+1] | term;
          end
        end
      end
    end else begin : g_ripple
      always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
          carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
      end
    end
  endgenerate

  assign sum = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one adder between NUM_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is one-hot or zero
//   req_in0/req_in1     : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake
//   rsp_id, rsp_sum     : winning requester and its WIDTH+1-bit sum
//   busy                : high whenever the FSM is not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrating; req_ready offered to the round-robin winner
// EXEC  | registered operands drive the adder; sum captured at edge
// RESP  | result presented, held until rsp_ready
module adder_rr_sched
  import arith_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int ALGORITHM = ALG_RIPPLE,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  output logic                     busy
);

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH:0]    sum_q;
  logic [WIDTH:0]    adder_sum;
  logic [ID_W-1:0]   grant;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [MAX_REQ-1:0] valid_ext;
  logic              handshake;

  assign valid_ext = MAX_REQ'(req_valid);
  assign grant     = ID_W'(rr_pick(valid_ext, 32'(rr_ptr_q), 32'(NUM_REQ)));

  // Gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && |req_valid) req_ready[grant] = 1'b1;
  end

  assign handshake = |req_ready;
  assign rr_ptr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_in0[i*WIDTH +: WIDTH];
        sel_b = req_in1[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      id_q     <= '0;
      sum_q    <= '0;
    end else begin
      if (state_q == IDLE && handshake) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        id_q     <= grant;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == EXEC) sum_q <= adder_sum;
    end
  end

  adder #(
    .WIDTH     (WIDTH),
    .ALGORITHM (ALGORITHM)
  ) u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (adder_sum)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign busy      = (state_q != IDLE);

endmodule
